// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: memory-control word fields, write-back
// control bits, and the registered load-steering payload.
package mem_access_stage_pkg;

  // Memory-control word layout, shared with the decoder.
  localparam int unsigned NB_MEM_CTRL    = 6;
  localparam int unsigned POS_MEM_RDWR   = 0;
  localparam int unsigned POS_MEM_BYENB  = 2;
  localparam int unsigned POS_MEM_EXTSIG = 4;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] MEM_BYENB_BYTE = 2'b00;
  localparam logic [1:0] MEM_BYENB_HALF = 2'b01;
  localparam logic [1:0] MEM_BYENB_WORD = 2'b11;

  localparam logic [1:0] MEM_EXTEND_NONE = 2'b00;
  localparam logic [1:0] MEM_EXTEND_BYTE = 2'b01;
  localparam logic [1:0] MEM_EXTEND_HALF = 2'b10;

  // Write-back control word: bit 0 enables the register-file write.
  localparam int unsigned NB_WRB_CTRL      = 2;
  localparam int unsigned POS_WRB_WRITEENB = 0;
  localparam int unsigned POS_WRB_MEMTOREG = 1;

  localparam int unsigned NB_BYTE  = 8;
  localparam int unsigned NB_LANES = 4;

  // Access attributes carried across the MEM/WB boundary to steer the load.
  typedef struct packed {
    logic [1:0] byenb;
    logic [1:0] extsig;
    logic [1:0] lane;
    logic       misaligned;
  } mem_rd_info_t;

  // Half accesses need an even address, word accesses a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] rdwr,
                                         input logic [1:0] byenb,
                                         input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (rdwr != MEM_NONE) begin
      if (byenb == MEM_BYENB_HALF && lane[0])
        mis = 1'b1;
      else if (byenb == MEM_BYENB_WORD && lane != 2'b00)
        mis = 1'b1;
    end
    return mis;
  endfunction

endpackage

// File: rtl/data_ram_bytewise.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port that holds its value when rd_en is low.
// Ports:
//   clk, rst_n  clock; synchronous active-low reset of the read register only
//   addr        word address
//   byte_we     one write enable per byte lane (little-endian)
//   wdata       write data, already replicated onto the enabled lanes
//   rd_en       load the read register this cycle
//   rdata       registered read word
module data_ram_bytewise #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NB_ADDR-1:0]   addr,
  input  logic [NB_DATA/8-1:0] byte_we,
  input  logic [NB_DATA-1:0]   wdata,
  input  logic                 rd_en,
  output logic [NB_DATA-1:0]   rdata
);

  localparam int unsigned NB_WE = NB_DATA / 8;
  localparam int unsigned DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_WE; i++) begin
      if (byte_we[i])
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Read register: cleared by reset, held while rd_en is low.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata <= '0;
    else if (rd_en)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word stores and loads on the internal data
// RAM, load-data extension, and the MEM/WB boundary register.
// Ports:
//   i_clock, i_reset   clock; synchronous active-low reset
//   i_valid            instruction present in MEM
//   i_stall, i_flush   hold the stage / kill the instruction in MEM
//   i_mem_ctrl         {extsig, byenb, rdwr}
//   i_wrb_ctrl         write-back control, passed through
//   i_alu_result       byte address for loads/stores, ALU value otherwise
//   i_store_data       store data
//   i_wreg             destination register index
//   o_*                MEM/WB outputs; o_read_data is the extended load word
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_ADDR     = 10,
  parameter int unsigned NB_REG_ADDR = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic [NB_MEM_CTRL-1:0] i_mem_ctrl,
  input  logic [NB_WRB_CTRL-1:0] i_wrb_ctrl,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic [NB_DATA-1:0]     i_store_data,
  input  logic [NB_REG_ADDR-1:0] i_wreg,
  output logic                   o_valid,
  output logic [NB_WRB_CTRL-1:0] o_wrb_ctrl,
  output logic [NB_DATA-1:0]     o_alu_result,
  output logic [NB_DATA-1:0]     o_read_data,
  output logic [NB_REG_ADDR-1:0] o_wreg,
  output logic                   o_misaligned
);

  logic [1:0]             rdwr;
  logic [1:0]             byenb;
  logic [1:0]             extsig;
  logic [1:0]             lane;
  logic [NB_ADDR-1:0]     word_idx;
  logic                   misaligned;
  logic                   wr_en;
  logic                   rd_en;
  logic                   live;
  logic [NB_LANES-1:0]    lane_mask;
  logic [NB_LANES-1:0]    byte_we;
  logic [NB_DATA-1:0]     ram_wdata;
  logic [NB_DATA-1:0]     ram_rdata;
  logic [NB_WRB_CTRL-1:0] wrb_masked;
  mem_rd_info_t           rd_info_q;
  logic [NB_BYTE-1:0]     sel_byte;
  logic [15:0]            sel_half;
  logic                   unused_addr_bits;

  assign rdwr     = i_mem_ctrl[POS_MEM_RDWR   +: 2];
  assign byenb    = i_mem_ctrl[POS_MEM_BYENB  +: 2];
  assign extsig   = i_mem_ctrl[POS_MEM_EXTSIG +: 2];
  assign lane     = i_alu_result[1:0];
  assign word_idx = i_alu_result[NB_ADDR+1:2];

  // Address bits above the RAM depth wrap around.
  assign unused_addr_bits = ^i_alu_result[NB_DATA-1:NB_ADDR+2];

  assign misaligned = is_misaligned(rdwr, byenb, lane);
  assign live       = i_valid & ~i_flush;
  assign wr_en      = i_valid & (rdwr == MEM_WRITE) & ~misaligned
                    & ~i_stall & ~i_flush & i_reset;
  // A flush still advances the stage, so the RAM output register moves too.
  assign rd_en      = i_flush | ~i_stall;

  // Store lane steering: replicate the source onto every lane it may land in.
  always_comb begin
    lane_mask = '0;
    ram_wdata = i_store_data;
    case (byenb)
      MEM_BYENB_BYTE: begin
        lane_mask = NB_LANES'(4'b0001 << lane);
        ram_wdata = {4{i_store_data[7:0]}};
      end
      MEM_BYENB_HALF: begin
        lane_mask = lane[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{i_store_data[15:0]}};
      end
      MEM_BYENB_WORD: lane_mask = 4'b1111;
      default:        lane_mask = '0;
    endcase
    byte_we = wr_en ? lane_mask : '0;
  end

  always_comb begin
    wrb_masked = i_wrb_ctrl;
    if (misaligned)
      wrb_masked[POS_WRB_WRITEENB] = 1'b0;
  end

  data_ram_bytewise #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_ram (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .addr    (word_idx),
    .byte_we (byte_we),
    .wdata   (ram_wdata),
    .rd_en   (rd_en),
    .rdata   (ram_rdata)
  );

  // MEM/WB boundary register; flush wins over stall.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_valid      <= 1'b0;
      o_wrb_ctrl   <= '0;
      o_alu_result <= '0;
      o_wreg       <= '0;
      rd_info_q    <= '0;
    end else if (i_flush || !i_stall) begin
      o_valid      <= live;
      o_wrb_ctrl   <= live ? wrb_masked : '0;
      o_alu_result <= i_alu_result;
      o_wreg       <= i_wreg;
      rd_info_q    <= '{byenb:      byenb,
                        extsig:     extsig,
                        lane:       lane,
                        misaligned: misaligned & live};
    end
  end

  assign o_misaligned = rd_info_q.misaligned;

  // Load extension from the registered RAM word.
  always_comb begin
    case (rd_info_q.lane)
      2'd0:    sel_byte = ram_rdata[7:0];
      2'd1:    sel_byte = ram_rdata[15:8];
      2'd2:    sel_byte = ram_rdata[23:16];
      default: sel_byte = ram_rdata[31:24];
    endcase
    sel_half = rd_info_q.lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    case (rd_info_q.byenb)
      MEM_BYENB_BYTE:
        o_read_data = (rd_info_q.extsig == MEM_EXTEND_BYTE)
                    ? {{(NB_DATA-8){sel_byte[7]}}, sel_byte}
                    : NB_DATA'(sel_byte);
      MEM_BYENB_HALF:
        o_read_data = (rd_info_q.extsig == MEM_EXTEND_HALF)
                    ? {{(NB_DATA-16){sel_half[15]}}, sel_half}
                    : NB_DATA'(sel_half);
      default:
        o_read_data = ram_rdata;
    endcase

    if (rd_info_q.misaligned)
      o_read_data = '0;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic [5:0]  i_mem_ctrl;
  logic [1:0]  i_wrb_ctrl;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [4:0]  i_wreg;
  logic        o_valid;
  logic [1:0]  o_wrb_ctrl;
  logic [31:0] o_alu_result;
  logic [31:0] o_read_data;
  logic [4:0]  o_wreg;
  logic        o_misaligned;

  int checks;
  int fails;

  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] BY = 2'b00;
  localparam logic [1:0] HF = 2'b01;
  localparam logic [1:0] WD = 2'b11;
  localparam logic [1:0] XN = 2'b00;
  localparam logic [1:0] XB = 2'b01;
  localparam logic [1:0] XH = 2'b10;

  mem_access_stage dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_mem_ctrl   (i_mem_ctrl),
    .i_wrb_ctrl   (i_wrb_ctrl),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_wreg       (i_wreg),
    .o_valid      (o_valid),
    .o_wrb_ctrl   (o_wrb_ctrl),
    .o_alu_result (o_alu_result),
    .o_read_data  (o_read_data),
    .o_wreg       (o_wreg),
    .o_misaligned (o_misaligned)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [1:0] rdwr, input logic [1:0] byenb,
                       input logic [1:0] ext, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] wrb,
                       input logic [4:0] wreg);
    i_valid = v;
    i_mem_ctrl = '0;
    i_mem_ctrl[POS_MEM_RDWR +: 2] = rdwr;
    i_mem_ctrl[POS_MEM_BYENB +: 2] = byenb;
    i_mem_ctrl[POS_MEM_EXTSIG +: 2] = ext;
    i_alu_result = addr;
    i_store_data = data;
    i_wrb_ctrl = wrb;
    i_wreg = wreg;
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    drive(1'b0, NO, WD, XN, 32'h0, 32'h0, 2'b00, 5'd0);
    step(); step();
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_wrb_ctrl !== 2'b00) begin fails++; $display("FAIL reset_wrb got %b exp 00", o_wrb_ctrl); end
    checks++; if (o_alu_result !== 32'h0) begin fails++; $display("FAIL reset_alu got %h exp 0", o_alu_result); end
    checks++; if (o_read_data !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", o_read_data); end
    checks++; if (o_wreg !== 5'd0) begin fails++; $display("FAIL reset_wreg got %0d exp 0", o_wreg); end
    checks++; if (o_misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis got %b exp 0", o_misaligned); end
    i_reset = 1'b1;
    step();
  endtask

  task automatic test_word();
    drive(1'b1, WR, WD, XN, 32'h10, 32'hDEADBEEF, 2'b00, 5'd0);
    step();
    checks++; if (o_valid !== 1'b1 || o_misaligned !== 1'b0) begin fails++; $display("FAIL sw_flags got v=%b m=%b exp v=1 m=0", o_valid, o_misaligned); end
    drive(1'b1, RD, WD, XN, 32'h10, 32'h0, 2'b11, 5'd5);
    step();
    checks++; if (o_read_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata got %h exp deadbeef", o_read_data); end
    checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL lw_valid got %b exp 1", o_valid); end
    checks++; if (o_wrb_ctrl !== 2'b11) begin fails++; $display("FAIL lw_wrb got %b exp 11", o_wrb_ctrl); end
    checks++; if (o_wreg !== 5'd5) begin fails++; $display("FAIL lw_wreg got %0d exp 5", o_wreg); end
    checks++; if (o_alu_result !== 32'h10) begin fails++; $display("FAIL lw_alu got %h exp 10", o_alu_result); end
  endtask

  task automatic test_extend();
    drive(1'b1, RD, BY, XB, 32'h13, 32'h0, 2'b11, 5'd1);
    step();
    checks++; if (o_read_data !== 32'hFFFFFFDE) begin fails++; $display("FAIL lb got %h exp ffffffde", o_read_data); end
    drive(1'b1, RD, BY, XN, 32'h13, 32'h0, 2'b11, 5'd1);
    step();
    checks++; if (o_read_data !== 32'h000000DE) begin fails++; $display("FAIL lbu got %h exp 000000de", o_read_data); end
    drive(1'b1, RD, HF, XH, 32'h12, 32'h0, 2'b11, 5'd1);
    step();
    checks++; if (o_read_data !== 32'hFFFFDEAD) begin fails++; $display("FAIL lh got %h exp ffffdead", o_read_data); end
    drive(1'b1, RD, HF, XN, 32'h10, 32'h0, 2'b11, 5'd1);
    step();
    checks++; if (o_read_data !== 32'h0000BEEF) begin fails++; $display("FAIL lhu got %h exp 0000beef", o_read_data); end
    drive(1'b1, RD, BY, XB, 32'h10, 32'h0, 2'b11, 5'd1);
    step();
    checks++; if (o_read_data !== 32'hFFFFFFEF) begin fails++; $display("FAIL lb_lane0 got %h exp ffffffef", o_read_data); end
  endtask

  task automatic test_partial();
    drive(1'b1, WR, BY, XN, 32'h11, 32'hAAAAAA55, 2'b00, 5'd0);
    step();
    drive(1'b1, RD, WD, XN, 32'h10, 32'h0, 2'b11, 5'd2);
    step();
    checks++; if (o_read_data !== 32'hDEAD55EF) begin fails++; $display("FAIL sb_lw got %h exp dead55ef", o_read_data); end
    drive(1'b1, WR, HF, XN, 32'h12, 32'hFFFF1234, 2'b00, 5'd0);
    step();
    drive(1'b1, RD, WD, XN, 32'h10, 32'h0, 2'b11, 5'd2);
    step();
    checks++; if (o_read_data !== 32'h123455EF) begin fails++; $display("FAIL sh_lw got %h exp 123455ef", o_read_data); end
    // Upper address bits wrap onto the same word.
    drive(1'b1, RD, WD, XN, 32'h00001010, 32'h0, 2'b11, 5'd2);
    step();
    checks++; if (o_read_data !== 32'h123455EF) begin fails++; $display("FAIL wrap_lw got %h exp 123455ef", o_read_data); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, WR, WD, XN, 32'h12, 32'h00000000, 2'b01, 5'd0);
    step();
    checks++; if (o_misaligned !== 1'b1) begin fails++; $display("FAIL sw_mis_flag got %b exp 1", o_misaligned); end
    checks++; if (o_wrb_ctrl !== 2'b00) begin fails++; $display("FAIL sw_mis_wrb got %b exp 00", o_wrb_ctrl); end
    checks++; if (o_read_data !== 32'h0) begin fails++; $display("FAIL sw_mis_rdata got %h exp 0", o_read_data); end
    drive(1'b1, RD, WD, XN, 32'h10, 32'h0, 2'b11, 5'd4);
    step();
    checks++; if (o_read_data !== 32'h123455EF) begin fails++; $display("FAIL mis_nowrite got %h exp 123455ef", o_read_data); end
    checks++; if (o_misaligned !== 1'b0) begin fails++; $display("FAIL lw_aligned_mis got %b exp 0", o_misaligned); end
    drive(1'b1, RD, HF, XH, 32'h11, 32'h0, 2'b11, 5'd4);
    step();
    checks++; if (o_misaligned !== 1'b1) begin fails++; $display("FAIL lh_mis_flag got %b exp 1", o_misaligned); end
    checks++; if (o_wrb_ctrl !== 2'b10) begin fails++; $display("FAIL lh_mis_wrb got %b exp 10", o_wrb_ctrl); end
    checks++; if (o_read_data !== 32'h0) begin fails++; $display("FAIL lh_mis_rdata got %h exp 0", o_read_data); end
    drive(1'b1, RD, BY, XN, 32'h11, 32'h0, 2'b11, 5'd4);
    step();
    checks++; if (o_read_data !== 32'h00000055 || o_misaligned !== 1'b0) begin fails++; $display("FAIL lbu_odd got %h m=%b exp 00000055 m=0", o_read_data, o_misaligned); end
    // Non-memory op at an odd "address" is never misaligned.
    drive(1'b1, NO, WD, XN, 32'h12345673, 32'h0, 2'b01, 5'd6);
    step();
    checks++; if (o_misaligned !== 1'b0 || o_wrb_ctrl !== 2'b01) begin fails++; $display("FAIL alu_op got m=%b wrb=%b exp m=0 wrb=01", o_misaligned, o_wrb_ctrl); end
    checks++; if (o_alu_result !== 32'h12345673) begin fails++; $display("FAIL alu_pass got %h exp 12345673", o_alu_result); end
  endtask

  task automatic test_stall();
    drive(1'b1, RD, WD, XN, 32'h10, 32'h0, 2'b11, 5'd7);
    step();
    drive(1'b1, WR, WD, XN, 32'h20, 32'hCAFEF00D, 2'b00, 5'd9);
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_alu_result !== 32'h10 || o_wreg !== 5'd7 || o_valid !== 1'b1 || o_read_data !== 32'h123455EF) begin
        fails++;
        $display("FAIL stall_hold cyc=%0d got alu=%h wreg=%0d v=%b rd=%h exp alu=10 wreg=7 v=1 rd=123455ef",
                 i, o_alu_result, o_wreg, o_valid, o_read_data);
      end
    end
    i_stall = 1'b0;
    step();
    checks++; if (o_alu_result !== 32'h20 || o_wreg !== 5'd9) begin fails++; $display("FAIL stall_release got alu=%h wreg=%0d exp alu=20 wreg=9", o_alu_result, o_wreg); end
    drive(1'b1, RD, WD, XN, 32'h20, 32'h0, 2'b11, 5'd3);
    step();
    checks++; if (o_read_data !== 32'hCAFEF00D) begin fails++; $display("FAIL stall_write got %h exp cafef00d", o_read_data); end
  endtask

  task automatic test_flush();
    drive(1'b1, WR, WD, XN, 32'h20, 32'h0BADF00D, 2'b01, 5'd8);
    i_stall = 1'b1; i_flush = 1'b1;
    step();
    checks++; if (o_valid !== 1'b0 || o_wrb_ctrl !== 2'b00 || o_misaligned !== 1'b0) begin fails++; $display("FAIL flush_stall got v=%b wrb=%b m=%b exp 0 00 0", o_valid, o_wrb_ctrl, o_misaligned); end
    i_stall = 1'b0;
    drive(1'b1, RD, HF, XH, 32'h11, 32'h0, 2'b11, 5'd8);
    step();
    checks++; if (o_valid !== 1'b0 || o_wrb_ctrl !== 2'b00 || o_misaligned !== 1'b0) begin fails++; $display("FAIL flush_mis got v=%b wrb=%b m=%b exp 0 00 0", o_valid, o_wrb_ctrl, o_misaligned); end
    i_flush = 1'b0;
    drive(1'b1, RD, WD, XN, 32'h20, 32'h0, 2'b11, 5'd3);
    step();
    checks++; if (o_read_data !== 32'hCAFEF00D || o_valid !== 1'b1) begin fails++; $display("FAIL flush_nowrite got %h v=%b exp cafef00d v=1", o_read_data, o_valid); end
  endtask

  task automatic test_invalid();
    drive(1'b0, WR, WD, XN, 32'h20, 32'h99999999, 2'b01, 5'd3);
    step();
    checks++; if (o_valid !== 1'b0 || o_wrb_ctrl !== 2'b00) begin fails++; $display("FAIL invalid_out got v=%b wrb=%b exp 0 00", o_valid, o_wrb_ctrl); end
    drive(1'b1, RD, WD, XN, 32'h20, 32'h0, 2'b11, 5'd3);
    step();
    checks++; if (o_read_data !== 32'hCAFEF00D) begin fails++; $display("FAIL invalid_nowrite got %h exp cafef00d", o_read_data); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, WR, WD, XN, 32'h30, 32'hA5A5C3C3, 2'b00, 5'd0);
    step();
    drive(1'b1, RD, HF, XH, 32'h32, 32'h0, 2'b11, 5'd11);
    step();
    checks++; if (o_read_data !== 32'hFFFFA5A5) begin fails++; $display("FAIL raw_b2b got %h exp ffffa5a5", o_read_data); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, RD, WD, XN, 32'h10, 32'h0, 2'b11, 5'd7);
    step();
    drive(1'b1, WR, WD, XN, 32'h20, 32'h77777777, 2'b01, 5'd9);
    i_reset = 1'b0;
    step();
    checks++;
    if (o_valid !== 1'b0 || o_wrb_ctrl !== 2'b00 || o_alu_result !== 32'h0 ||
        o_read_data !== 32'h0 || o_wreg !== 5'd0 || o_misaligned !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got v=%b wrb=%b alu=%h rd=%h wreg=%0d m=%b exp all 0",
               o_valid, o_wrb_ctrl, o_alu_result, o_read_data, o_wreg, o_misaligned);
    end
    i_reset = 1'b1;
    drive(1'b1, RD, WD, XN, 32'h20, 32'h0, 2'b11, 5'd3);
    step();
    checks++; if (o_read_data !== 32'hCAFEF00D) begin fails++; $display("FAIL reset_nowrite got %h exp cafef00d", o_read_data); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_misaligned();
    test_stall();
    test_flush();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
